fork_join_timer: RTL

- Synthesizable, parametrised timed fork/join engine with NCH parallel channels sharing one elapsed-cycle counter.
- Each channel writes its value to a common output register after its own programmed delay.
- An iteration ends (join) only when every channel has fired. With loop set, the engine re-forks automatically, like a repeating always-fork block.
- Used as a stimulus/event sequencer inside directed test harnesses.

---
 rtl/fork_join_timer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fork_join_timer.sv
// rtl/fork_join_timer.sv - timed fork/join engine: NCH channels fire after per-channel delays, join when all fired
// Optional macro FORK_JOIN_TIMER_ACCUM_EN: out_val accumulates fired channel values per iteration instead of overwriting.
module fork_join_timer #(
   parameter int NCH   = 2,
   parameter int WIDTH = 4,
   parameter int DW    = 8,
   parameter int CW    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 loop,
   input  logic                 abort,
   input  logic [NCH*DW-1:0]    dly,
   input  logic [NCH*WIDTH-1:0] val,
   output logic [WIDTH-1:0]     out_val,
   output logic                 out_valid,
   output logic [NCH-1:0]       fire_mask,
   output logic                 busy,
   output logic                 done,
   output logic [CW-1:0]        iter_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, JOIN} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [DW:0]          cnt;        // one spare bit so a 2^DW-1 delay never sees a wrap
   logic [NCH*DW-1:0]    dly_sh;
   logic [NCH*WIDTH-1:0] val_sh;
   logic [NCH-1:0]       fire_now;
   logic [WIDTH-1:0]     fire_val;
   logic                 fork_now;

   assign busy = (state != IDLE);

   // Ascending loop: in overwrite mode the highest firing index wins out_val.
   always_comb begin
      fire_now = '0;
      fire_val = out_val;
      for (int i = 0; i < NCH; i++) begin
         if (!fire_mask[i] && (cnt == {1'b0, dly_sh[i*DW +: DW]})) begin
            fire_now[i] = 1'b1;
`ifdef FORK_JOIN_TIMER_ACCUM_EN
            fire_val = fire_val + val_sh[i*WIDTH +: WIDTH];
`else
            fire_val = val_sh[i*WIDTH +: WIDTH];
`endif
         end
      end
   end

   always_comb begin
      state_nxt = state;
      fork_now  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = RUN;
               fork_now  = 1'b1;
            end
         end
         RUN: begin
            if (abort)
               state_nxt = IDLE;
            else if ((fire_mask | fire_now) == '1)
               state_nxt = JOIN;
         end
         JOIN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (loop) begin
               state_nxt = RUN;
               fork_now  = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         dly_sh    <= '0;
         val_sh    <= '0;
         out_val   <= '0;
         out_valid <= 1'b0;
         fire_mask <= '0;
         done      <= 1'b0;
         iter_cnt  <= '0;
      end else begin
         out_valid <= 1'b0;
         done      <= 1'b0;
         if (fork_now) begin
            dly_sh    <= dly;
            val_sh    <= val;
            cnt       <= '0;
            fire_mask <= '0;
`ifdef FORK_JOIN_TIMER_ACCUM_EN
            out_val   <= '0;
`endif
         end
         if (state == RUN && !abort) begin
            cnt       <= cnt + 1'b1;
            fire_mask <= fire_mask | fire_now;
            if (|fire_now) begin
               out_val   <= fire_val;
               out_valid <= 1'b1;
            end
         end
         if (state != IDLE && abort)
            fire_mask <= '0;
         if (state == JOIN && !abort) begin
            done     <= 1'b1;
            iter_cnt <= iter_cnt + 1'b1;
         end
      end
   end

endmodule
